// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demultiplexer. Each channel has a one-entry holding
// register, and there is a broadcast mode and a saturating count of words dropped for an illegal select.
module stream_demux #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_bcast,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_OUT*DATA_W-1:0]  out_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [7:0]                 err_cnt
);

  localparam int              NSEL      = 1 << SEL_W;
  localparam logic [SEL_W:0]  NUM_OUT_L = (SEL_W + 1)'(NUM_OUT);

  logic [DATA_W-1:0]  data_q [NUM_OUT];
  logic [NUM_OUT-1:0] valid_q, valid_d;
  logic [NUM_OUT-1:0] slot_free, load;
  logic [NSEL-1:0]    free_pad, sel_dec;
  logic [7:0]         err_q, err_d;
  logic               sel_legal, accept;

  always_comb begin
    slot_free = ~valid_q | out_ready;
    // Pad to the full select range so any in_sel indexes in bounds.
    free_pad                = '0;
    free_pad[NUM_OUT-1:0]   = slot_free;
    sel_dec                 = '0;
    sel_dec[in_sel]         = 1'b1;
    sel_legal = {1'b0, in_sel} < NUM_OUT_L;

    if (in_bcast)       in_ready = &slot_free;
    else if (sel_legal) in_ready = free_pad[in_sel];
    else                in_ready = 1'b1;

    accept = in_valid & in_ready;
    load   = '0;
    if (accept) load = in_bcast ? '1 : sel_dec[NUM_OUT-1:0];

    valid_d = load | (valid_q & ~out_ready);

    err_d = err_q;
    if (accept && !in_bcast && !sel_legal && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int unsigned k = 0; k < NUM_OUT; k++)
        if (load[k]) data_q[k] <= in_data;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) out_data[k*DATA_W +: DATA_W] = data_q[k];
  end

  assign out_valid = valid_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux. It drives a 4-channel instance and a 3-channel instance for illegal selects,
// and checks both against a behavioural model on every cycle, plus directed expectations.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast, in_valid, in_valid3;
  logic        in_ready, in_ready3;
  logic [31:0] out_data;
  logic [23:0] out_data3;
  logic [3:0]  out_valid, out_ready;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = 3'b111;
  logic [7:0]  err_cnt, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_cnt(err_cnt));

  stream_demux #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .err_cnt(err3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 is the 4-channel instance, index 1 is the 3-channel instance.
  logic       mv [2][4];
  logic [7:0] md [2][4];
  int         merr [2];

  function automatic logic mready(int m, int n, logic [1:0] sel, logic bc, logic [3:0] rdy);
    logic all_free = 1'b1;
    for (int k = 0; k < n; k++) all_free &= (!mv[m][k] || rdy[k]);
    if (bc) return all_free;
    if (int'(sel) < n) return !mv[m][sel] || rdy[sel];
    return 1'b1;
  endfunction

  task automatic mstep(int m, int n, logic v, logic [3:0] rdy);
    logic r = mready(m, n, in_sel, in_bcast, rdy);
    for (int k = 0; k < n; k++) if (mv[m][k] && rdy[k]) mv[m][k] = 1'b0;
    if (v && r) begin
      if (in_bcast) begin
        for (int k = 0; k < n; k++) begin mv[m][k] = 1'b1; md[m][k] = in_data; end
      end else if (int'(in_sel) < n) begin
        mv[m][in_sel] = 1'b1; md[m][in_sel] = in_data;
      end else if (merr[m] < 255) merr[m]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        merr[m] = 0;
        for (int k = 0; k < 4; k++) begin mv[m][k] = 1'b0; md[m][k] = 8'h00; end
      end
    end else begin
      mstep(0, 4, in_valid, out_ready);
      mstep(1, 3, in_valid3, {1'b0, out_ready3});
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(mready(0, 4, in_sel, in_bcast, out_ready)));
    for (int k = 0; k < 4; k++) begin
      chk("out_valid", 32'(out_valid[k]), 32'(mv[0][k]));
      chk("out_data", 32'(out_data[k*8 +: 8]), 32'(md[0][k]));
    end
    chk("err_cnt", 32'(err_cnt), 32'(merr[0]));
    chk("in_ready3", 32'(in_ready3), 32'(mready(1, 3, in_sel, in_bcast, 4'b0111)));
    for (int k = 0; k < 3; k++) begin
      chk("out_valid3", 32'(out_valid3[k]), 32'(mv[1][k]));
      chk("out_data3", 32'(out_data3[k*8 +: 8]), 32'(md[1][k]));
    end
    chk("err3", 32'(err3), 32'(merr[1]));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0;
    in_valid = 1'b0; in_valid3 = 1'b0; out_ready = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);
    #2 rst_n = 1'b1;

    // Unicast sweep
    for (int k = 0; k < 4; k++) begin
      tick(); in_valid = 1'b1; in_data = 8'(8'hA0 + k); in_sel = 2'(k);
      @(negedge clk);
      chk("sweep_ready", 32'(in_ready), 32'h1);
      if (k > 0) begin
        chk("sweep_valid", 32'(out_valid), 32'(4'(1 << (k - 1))));
        chk("sweep_data", 32'(out_data[(k-1)*8 +: 8]), 32'(8'hA0 + k - 1));
      end
    end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("sweep_valid", 32'(out_valid), 32'h8);
    chk("sweep_data", 32'(out_data[31:24]), 32'hA3);
    tick(); @(negedge clk);
    chk("sweep_idle", 32'(out_valid), 32'h0);

    // Backpressure on channel 2
    tick(); out_ready = 4'b1011; in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd2;
    @(negedge clk); chk("bp_ready1", 32'(in_ready), 32'h1);
    tick(); in_data = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall", 32'(in_ready), 32'h0);
      chk("bp_hold", 32'(out_data[23:16]), 32'h11);
      chk("bp_valid", 32'(out_valid), 32'h4);
      tick();
    end
    in_data = 8'h33; in_sel = 2'd1;
    @(negedge clk); chk("bp_ch1_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("bp_ch1_valid", 32'(out_valid), 32'h6);
    chk("bp_ch1_data", 32'(out_data[15:8]), 32'h33);
    tick(); out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h22; in_sel = 2'd2;
    @(negedge clk);
    chk("bp_rel_ready", 32'(in_ready), 32'h1);
    chk("bp_rel_first", 32'(out_data[23:16]), 32'h11);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("bp_rel_valid", 32'(out_valid), 32'h4);
    chk("bp_rel_second", 32'(out_data[23:16]), 32'h22);
    tick(); @(negedge clk);
    chk("bp_idle", 32'(out_valid), 32'h0);

    // Broadcast blocked by full channel 2
    tick(); out_ready = 4'b1011; in_valid = 1'b1; in_data = 8'h77; in_sel = 2'd2;
    tick(); in_bcast = 1'b1; in_data = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bc_stall", 32'(in_ready), 32'h0);
      chk("bc_noload", 32'(out_valid), 32'h4);
      tick();
    end
    out_ready = 4'hF;
    @(negedge clk); chk("bc_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0; in_bcast = 1'b0;
    @(negedge clk);
    chk("bc_valid", 32'(out_valid), 32'hF);
    chk("bc_data", out_data, 32'h5A5A5A5A);
    tick(); @(negedge clk);
    chk("bc_idle", 32'(out_valid), 32'h0);

    // Illegal select on the 3-channel instance
    tick(); in_sel = 2'd3; in_valid3 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      @(negedge clk);
      chk("ill_ready", 32'(in_ready3), 32'h1);
      chk("ill_novalid", 32'(out_valid3), 32'h0);
      if (i == 254) chk("ill_err254", 32'(err3), 32'd254);
      if (i == 255) chk("ill_err255", 32'(err3), 32'd255);
      tick();
    end
    in_valid3 = 1'b0;
    @(negedge clk); chk("ill_sat", 32'(err3), 32'd255);

    // Reset mid-stream
    tick(); out_ready = 4'b1001; in_valid = 1'b1; in_data = 8'h61; in_sel = 2'd1;
    tick(); in_data = 8'h62; in_sel = 2'd2;
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("mr_held", 32'(out_valid), 32'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_data", out_data, 32'h0);
    chk("mr_err", 32'(err_cnt), 32'h0);
    chk("mr_err3", 32'(err3), 32'h0);
    #1 rst_n = 1'b1;
    tick(); out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h99; in_sel = 2'd0;
    @(negedge clk); chk("mr_resume_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("mr_resume_valid", 32'(out_valid), 32'h1);
    chk("mr_resume_data", 32'(out_data[7:0]), 32'h99);

    // Full-throughput streaming on channel 0
    for (int i = 0; i < 16; i++) begin
      tick(); in_valid = 1'b1; in_data = 8'(i); in_sel = 2'd0;
      @(negedge clk);
      chk("st_ready", 32'(in_ready), 32'h1);
      if (i > 1) begin
        chk("st_valid", 32'(out_valid[0]), 32'h1);
        chk("st_data", 32'(out_data[7:0]), 32'(i - 1));
      end
    end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("st_last_valid", 32'(out_valid[0]), 32'h1);
    chk("st_last_data", 32'(out_data[7:0]), 32'd15);
    tick(); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
